// File: rtl/aes_stream_transactor_if.sv
// Stream and DUT-side bundle for aes_stream_transactor.
// The slave modport is the transactor's view; master is the environment's view.
interface aes_stream_transactor_if #(
  parameter int STATE_BITS = 128,
  parameter int KEY_BITS   = 128
);
  logic                  in_valid;
  logic                  in_ready;
  logic [STATE_BITS-1:0] in_data;
  logic [KEY_BITS-1:0]   in_key;
  logic                  in_eom;

  logic [STATE_BITS-1:0] dut_data;
  logic [KEY_BITS-1:0]   dut_key;
  logic [KEY_BITS-1:0]   dut_dec_key;
  logic [STATE_BITS-1:0] dut_enc_data;
  logic [STATE_BITS-1:0] dut_dec_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [STATE_BITS-1:0] out_cipher;
  logic [STATE_BITS-1:0] out_plain;
  logic                  out_eom;

  modport slave (
    input  in_valid, in_data, in_key, in_eom, out_ready, dut_enc_data, dut_dec_data,
    output in_ready, dut_data, dut_key, dut_dec_key, out_valid, out_cipher, out_plain, out_eom
  );

  modport master (
    output in_valid, in_data, in_key, in_eom, out_ready, dut_enc_data, dut_dec_data,
    input  in_ready, dut_data, dut_key, dut_dec_key, out_valid, out_cipher, out_plain, out_eom
  );
endinterface

// File: rtl/aes_stream_transactor.sv
// Issues {plaintext, key} into a fixed-latency AES enc->dec pipeline and queues aligned
// {cipher, plain', eom} results in a credit-protected FIFO. Optional counters: AES_XTOR_STATS_EN.
module aes_stream_transactor #(
  parameter int STATE_BITS  = 128,
  parameter int KEY_BITS    = 128,
  parameter int ENC_LATENCY = 10,
  parameter int DEC_LATENCY = 10,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  aes_stream_transactor_if.slave      bus,
  output logic                        done,
  output logic [31:0]                 stat_blocks,
  output logic [31:0]                 stat_stalls
);
  localparam int TAG_LEN = ENC_LATENCY + DEC_LATENCY;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 2;
  localparam int EW      = 2 * STATE_BITS + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic                  issue_vld_q, issue_vld_d;
  logic                  issue_eom_q, issue_eom_d;
  logic [TAG_LEN-1:0]    tag_q, tag_d;
  logic [TAG_LEN-1:0]    eom_line_q, eom_line_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [STATE_BITS-1:0] dut_data_q, dut_data_d;
  logic [KEY_BITS-1:0]   dut_key_q, dut_key_d;
  logic [KEY_BITS-1:0]   key_line_q [ENC_LATENCY];
  logic [KEY_BITS-1:0]   key_line_d [ENC_LATENCY];
  logic [STATE_BITS-1:0] cipher_line_q [DEC_LATENCY];
  logic [STATE_BITS-1:0] cipher_line_d [DEC_LATENCY];
  logic [EW-1:0]         fifo_q [FIFO_DEPTH];
  logic [EW-1:0]         fifo_d [FIFO_DEPTH];

  logic [CW-1:0]         credit_used;
  logic                  in_ready;
  logic                  accept;
  logic                  tag_exit;
  logic                  out_valid;
  logic                  pop;
  logic [EW-1:0]         push_entry;
  logic [EW-1:0]         head;

  // Credits cover both in-flight elements and queued results, so the FIFO cannot overflow.
  assign credit_used = count_q + inflight_q;
  assign in_ready    = (state_q == RUN) && (credit_used < DEPTH_C);
  assign accept      = bus.in_valid && in_ready;
  assign tag_exit    = tag_q[TAG_LEN-1];
  assign out_valid   = (count_q != '0);
  assign pop         = out_valid && bus.out_ready;
  assign push_entry  = {cipher_line_q[DEC_LATENCY-1], bus.dut_dec_data, eom_line_q[TAG_LEN-1]};
  assign head        = fifo_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (accept && bus.in_eom) state_d = DRAIN;
      DRAIN:   if (inflight_d == '0 && count_d == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    issue_vld_d = accept;
    issue_eom_d = accept ? bus.in_eom  : issue_eom_q;
    dut_data_d  = accept ? bus.in_data : dut_data_q;
    dut_key_d   = accept ? bus.in_key  : dut_key_q;
    tag_d       = {tag_q[TAG_LEN-2:0], issue_vld_q};
    eom_line_d  = {eom_line_q[TAG_LEN-2:0], issue_eom_q};

    inflight_d = inflight_q;
    if (accept && !tag_exit)      inflight_d = inflight_q + CNT_ONE;
    else if (!accept && tag_exit) inflight_d = inflight_q - CNT_ONE;

    count_d = count_q;
    if (tag_exit && !pop)      count_d = count_q + CNT_ONE;
    else if (!tag_exit && pop) count_d = count_q - CNT_ONE;

    wr_ptr_d = tag_exit ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop      ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_comb begin
    key_line_d[0] = dut_key_q;
    for (int i = 1; i < ENC_LATENCY; i++) key_line_d[i] = key_line_q[i-1];
    cipher_line_d[0] = bus.dut_enc_data;
    for (int i = 1; i < DEC_LATENCY; i++) cipher_line_d[i] = cipher_line_q[i-1];
    fifo_d = fifo_q;
    if (tag_exit) fifo_d[wr_ptr_q] = push_entry;
  end

  // dut_* and the key line clear on reset so the encoder sees defined inputs after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      issue_vld_q <= 1'b0;
      tag_q       <= '0;
      inflight_q  <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dut_data_q  <= '0;
      dut_key_q   <= '0;
    end else begin
      state_q     <= state_d;
      issue_vld_q <= issue_vld_d;
      tag_q       <= tag_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      dut_data_q  <= dut_data_d;
      dut_key_q   <= dut_key_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < ENC_LATENCY; i++) key_line_q[i] <= reset ? '0 : key_line_d[i];
  end

  // Payload lines are only meaningful where a tag rides alongside them.
  always_ff @(posedge clock) begin
    issue_eom_q   <= issue_eom_d;
    eom_line_q    <= eom_line_d;
    cipher_line_q <= cipher_line_d;
    fifo_q        <= fifo_d;
  end

  assign bus.in_ready    = in_ready;
  assign bus.dut_data    = dut_data_q;
  assign bus.dut_key     = dut_key_q;
  assign bus.dut_dec_key = key_line_q[ENC_LATENCY-1];
  assign bus.out_valid   = out_valid;
  assign bus.out_cipher  = head[EW-1 -: STATE_BITS];
  assign bus.out_plain   = head[STATE_BITS:1];
  assign bus.out_eom     = out_valid && head[0];
  assign done            = (state_q == DONE);

`ifdef AES_XTOR_STATS_EN
  logic [31:0] blocks_q, blocks_d;
  logic [31:0] stalls_q, stalls_d;

  always_comb begin
    blocks_d = accept ? blocks_q + 32'd1 : blocks_q;
    stalls_d = (bus.in_valid && !in_ready && state_q == RUN) ? stalls_q + 32'd1 : stalls_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      blocks_q <= '0;
      stalls_q <= '0;
    end else begin
      blocks_q <= blocks_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_blocks = blocks_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_blocks = '0;
  assign stat_stalls = '0;
`endif
endmodule
